// File: rtl/ppo_result_router.sv
// ppo_result_router
//   Return path of the systolic array. Each result row is steered to one of
//   four phase sinks: 0 inf, 1 fw, 2 bw, 3 wu. The phase is latched once per
//   pass of ROWS_PER_PASS rows. A 2-entry FIFO sits between the array output
//   and sink back-pressure.
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   mode_in, mode_load   phase for the next pass, 1-cycle strobe to start it
//   busy                 a pass is in progress
//   in_data/valid/ready  row stream from the array
//   out_data             FIFO head row, shared by all sinks
//   out_valid/out_ready  per-sink handshake; only bit[mode] is active
//   row_idx              index within the pass of the row on out_data
//   pass_done            1-cycle pulse after the last row of a pass leaves
//   pass_cnt             completed passes, wrapping
module ppo_result_router #(
  parameter int dataWidth     = 32,
  parameter int SysDimension  = 16,
  parameter int ROWS_PER_PASS = 16,
  parameter int CNT_W         = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [1:0]                            mode_in,
  input  logic                                  mode_load,
  output logic                                  busy,
  input  logic [dataWidth*SysDimension-1:0]     in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [dataWidth*SysDimension-1:0]     out_data,
  output logic [3:0]                            out_valid,
  input  logic [3:0]                            out_ready,
  output logic [$clog2(ROWS_PER_PASS)-1:0]      row_idx,
  output logic                                  pass_done,
  output logic [CNT_W-1:0]                      pass_cnt
);

  localparam int ROW_W = dataWidth * SysDimension;
  localparam int IDX_W = $clog2(ROWS_PER_PASS);
  localparam int ACC_W = $clog2(ROWS_PER_PASS + 1);
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ROWS_PER_PASS - 1);
  localparam logic [ACC_W-1:0] ACC_FULL = ACC_W'(ROWS_PER_PASS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         mode_reg;
  logic [ROW_W-1:0]   head_reg;   // FIFO head, drives out_data directly
  logic [ROW_W-1:0]   tail_reg;   // second FIFO entry
  logic [1:0]         count_reg;
  logic [ACC_W-1:0]   acc_reg;    // rows accepted in the current pass
  logic [IDX_W-1:0]   row_idx_reg;
  logic               pass_done_reg;
  logic [CNT_W-1:0]   pass_cnt_reg;

  logic in_ready_int, push, pop, last_pop;

  // in_ready depends on registered state only, so sink ready never reaches
  // the array side combinationally; a full FIFO that pops delays the next push.
  always_comb begin
    in_ready_int = (state_reg == RUN) && (count_reg != 2'd2) && (acc_reg < ACC_FULL);
    push         = in_valid && in_ready_int;
    pop          = (count_reg != 2'd0) && out_ready[mode_reg];
    // No pushes happen in DRAIN, so popping the only entry ends the pass.
    last_pop     = (state_reg == DRAIN) && pop && (count_reg == 2'd1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mode_load) state_next = RUN;
      RUN:     if (push && (acc_reg == ACC_LAST)) state_next = DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid           = 4'b0000;
    out_valid[mode_reg] = (count_reg != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_reg      <= 2'b00;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= 2'd0;
      acc_reg       <= '0;
      row_idx_reg   <= '0;
      pass_done_reg <= 1'b0;
      pass_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pass_done_reg <= last_pop;
      if (last_pop) pass_cnt_reg <= pass_cnt_reg + CNT_W'(1);

      if ((state_reg == IDLE) && mode_load) begin
        mode_reg    <= mode_in;
        acc_reg     <= '0;
        row_idx_reg <= '0;
      end else begin
        if (push) acc_reg <= acc_reg + ACC_W'(1);
        if (pop)  row_idx_reg <= row_idx_reg + IDX_W'(1);
      end

      // Head stays put when the FIFO drains empty, so out_data keeps the last row.
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= in_data;
          else                   tail_reg <= in_data;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) head_reg <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        // Simultaneous push and pop is only possible with one entry held.
        2'b11:   head_reg <= in_data;
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign in_ready  = in_ready_int;
  assign out_data  = head_reg;
  assign row_idx   = row_idx_reg;
  assign pass_done = pass_done_reg;
  assign pass_cnt  = pass_cnt_reg;

endmodule

// File: tb/tb_ppo_result_router.sv
// tb_ppo_result_router
//   Directed bench for ppo_result_router (narrow rows, 2-bit pass counter).
//   Expected rows are queued on input accept and compared on output accept;
//   a small behavioural model supplies the expected control outputs.
module tb_ppo_result_router;

  localparam int DW = 8;
  localparam int SD = 4;
  localparam int RW = DW * SD;
  localparam int ROWS = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode_in;
  logic          mode_load;
  logic          busy;
  logic [RW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [3:0]    row_idx;
  logic          pass_done;
  logic [CW-1:0] pass_cnt;

  ppo_result_router #(
    .dataWidth(DW), .SysDimension(SD), .ROWS_PER_PASS(ROWS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .mode_load(mode_load), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .row_idx(row_idx), .pass_done(pass_done), .pass_cnt(pass_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  logic [RW-1:0] q[$];
  logic [RW-1:0] exp_last = '0;
  int            exp_state = 0;   // 0 idle, 1 run, 2 drain
  logic [1:0]    exp_mode = 2'b00;
  int            exp_acc = 0;
  int            exp_idx = 0;
  int            exp_cnt = 0;
  logic          exp_done = 1'b0;

  // Row source
  int            to_send = 0;
  logic [RW-1:0] cur_data;
  int            busy_cycles = 0;
  int            done_seen = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // then drive the next inputs just after the rising edge.
  task automatic tick();
    logic          push, pop, exp_ir;
    logic [3:0]    exp_ov;
    logic [RW-1:0] exp_head;
    int            old_state;
    @(negedge clk);
    exp_ir   = (exp_state == 1) && (q.size() < 2) && (exp_acc < ROWS);
    exp_ov   = (q.size() != 0) ? (4'b0001 << exp_mode) : 4'b0000;
    exp_head = (q.size() != 0) ? q[0] : exp_last;
    chk("busy",      busy,      (exp_state != 0));
    chk("in_ready",  in_ready,  exp_ir);
    chk("out_valid", out_valid, exp_ov);
    chk("out_data",  out_data,  exp_head);
    chk("row_idx",   row_idx,   exp_idx);
    chk("pass_done", pass_done, exp_done);
    chk("pass_cnt",  pass_cnt,  exp_cnt);
    if (busy) busy_cycles++;
    if (pass_done) done_seen++;
    push = in_valid && exp_ir;
    pop  = (q.size() != 0) && out_ready[exp_mode];
    old_state = exp_state;
    if (rst) begin
      q.delete();
      exp_last = '0; exp_state = 0; exp_mode = 2'b00;
      exp_acc = 0; exp_idx = 0; exp_cnt = 0; exp_done = 1'b0;
      push = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (pop) begin
        exp_last = q.pop_front();
        exp_idx  = (exp_idx + 1) % ROWS;
        if (old_state == 2 && q.size() == 0) begin
          exp_state = 0;
          exp_cnt   = (exp_cnt + 1) % 4;
          exp_done  = 1'b1;
        end
      end
      if (push) begin
        q.push_back(in_data);
        exp_acc++;
        if (exp_acc == ROWS) exp_state = 2;
      end
      if (old_state == 0 && mode_load) begin
        exp_mode = mode_in; exp_acc = 0; exp_idx = 0; exp_state = 1;
      end
    end
    @(posedge clk);
    #1;
    if (push) begin
      to_send--;
      cur_data = $urandom;
    end
    in_valid = (to_send > 0);
    in_data  = cur_data;
  endtask

  task automatic load(input logic [1:0] m);
    mode_in   = m;
    mode_load = 1'b1;
    tick();
    mode_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (exp_state != 0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_bounded"}, (n < 300), 1'b1);
    tick();
    tick();
  endtask

  initial begin
    int d0, b0, n;
    int seq[5];
    seq = '{1, 2, 3, 0, 1};
    rst = 1'b1; mode_in = 2'b00; mode_load = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 4'b0000;
    cur_data = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // 1: bw pass at full rate; in_valid raised while IDLE must be ignored
    out_ready = 4'b0100;
    to_send = ROWS; in_valid = 1'b1; in_data = cur_data;
    tick();
    tick();
    d0 = done_seen; busy_cycles = 0;
    load(2'b10);
    wait_idle("t1");
    chk("t1_done_pulses", done_seen - d0, 1);
    chk("t1_busy_cycles", busy_cycles, ROWS + 1);
    chk("t1_pass_cnt", pass_cnt, 1);

    // 2: fw pass with a 5-cycle sink stall mid-stream
    out_ready = 4'b0010;
    to_send = ROWS;
    load(2'b01);
    repeat (4) tick();
    out_ready = 4'b0000;
    repeat (5) tick();
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_valid_stall", out_valid, 4'b0010);
    out_ready = 4'b0010;
    wait_idle("t2");

    // 3: wu pass with only the wrong sink ready, then the right one
    out_ready = 4'b0001;
    to_send = ROWS;
    load(2'b11);
    repeat (20) tick();
    chk("t3_row_idx_stuck", row_idx, 0);
    out_ready = 4'b1000;
    wait_idle("t3");

    // 4: load strobes in RUN and on the final-pop edge are ignored
    out_ready = 4'b0010;
    to_send = ROWS;
    load(2'b01);
    repeat (3) tick();
    load(2'b00);
    n = 0;
    while (exp_state != 2 && n < 100) begin tick(); n++; end
    chk("t4_reach_drain", (n < 100), 1'b1);
    load(2'b00);
    b0 = done_seen;
    wait_idle("t4");
    chk("t4_one_done", done_seen - b0, 1);
    out_ready = 4'b0001;
    to_send = ROWS;
    load(2'b00);
    wait_idle("t4b");

    // 5: reset in the middle of a pass
    out_ready = 4'b0100;
    to_send = ROWS;
    load(2'b10);
    n = 0;
    while (exp_idx != 8 && n < 100) begin tick(); n++; end
    chk("t5_reach_row8", (n < 100), 1'b1);
    to_send = 0; in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_cnt", pass_cnt, 0);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_idx", row_idx, 0);
    chk("t5_rst_busy", busy, 0);

    // 6: five passes through the 2-bit counter
    for (int p = 0; p < 5; p++) begin
      out_ready = 4'b0001 << (p % 4);
      to_send = ROWS;
      load(2'(p % 4));
      wait_idle("t6");
      chk("t6_pass_cnt", pass_cnt, seq[p]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
